// File: rtl/elevator_pkg.sv
// Shared elevator constants, the pending-request bundle type and a floor decode helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elevator_pkg;

  localparam int         NUM_FLOORS = 5;
  localparam int         FLOOR_W    = 3;
  localparam int         FLOOR_TOP  = NUM_FLOORS - 1;
  localparam logic       DIR_UP     = 1'b1;
  localparam logic       DIR_DOWN   = 1'b0;

  // The three pending-request vectors travel together; bit N = floor N.
  typedef struct packed {
    logic [NUM_FLOORS-1:0] up;
    logic [NUM_FLOORS-1:0] dn;
    logic [NUM_FLOORS-1:0] car;
  } req_vec_t;

  // One-hot decode of a floor number; out-of-range floors decode to all zeros.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    floor_onehot = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (f == FLOOR_W'(i)) floor_onehot[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces one raw push button, emitting a single-cycle press event.
// Latency: raw edge to press_evt = 2 (sync) + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press_evt is a one-cycle pulse that must be consumed immediately.
//
// Ports: clk, rst (sync, active-high), btn_raw (async button), press_evt (1-cycle pulse).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [1:0]       prime;
  logic             armed;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // prime marks when sync_q carries real post-reset data. armed stays low until
  // the button has been seen released after reset, so a button held across a
  // reset never produces an event until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      prime     <= 2'b00;
      armed     <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
      prime     <= {prime[0], 1'b1};
      press_evt <= 1'b0;

      if (prime[1] && !sync_q) armed <= 1'b1;

      if (sync_q != level) begin
        // Any cycle where the input agrees with the accepted level restarts the count.
        if (cnt == CNT_LAST) begin
          level     <= sync_q;
          cnt       <= '0;
          press_evt <= sync_q & armed;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/call_request_register.sv
// Elevator call register: latches debounced hall/car button presses, clears them on service.
// Latency: press to LED = 2 + DEBOUNCE_CYCLES + 1 cycles; serve to clear = 1 cycle.
// Backpressure: none; every press event and serve pulse is absorbed in the cycle it occurs.
//
// Ports: clk, rst (sync, active-high); floor_N_p hall buttons, direction_N hall direction
// (1=up), floor_N_d car buttons; current_floor/serve_valid/serve_dir from the controller;
// pend_up/pend_down/pend_car request vectors, led_inside_N/led_outside_N lamps, any_pending.
module call_request_register
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  floor_0_p,
  input  logic                  floor_1_p,
  input  logic                  floor_2_p,
  input  logic                  floor_3_p,
  input  logic                  floor_4_p,
  input  logic                  direction_1,
  input  logic                  direction_2,
  input  logic                  direction_3,
  input  logic                  floor_0_d,
  input  logic                  floor_1_d,
  input  logic                  floor_2_d,
  input  logic                  floor_3_d,
  input  logic                  floor_4_d,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  serve_valid,
  input  logic                  serve_dir,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_down,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic                  led_inside_0,
  output logic                  led_inside_1,
  output logic                  led_inside_2,
  output logic                  led_inside_3,
  output logic                  led_inside_4,
  output logic                  led_outside_0,
  output logic                  led_outside_1,
  output logic                  led_outside_2,
  output logic                  led_outside_3,
  output logic                  led_outside_4,
  output logic                  any_pending
);

  logic [NUM_FLOORS-1:0] hall_raw;
  logic [NUM_FLOORS-1:0] car_raw;
  logic [NUM_FLOORS-1:0] hall_evt;
  logic [NUM_FLOORS-1:0] car_evt;

  assign hall_raw = {floor_4_p, floor_3_p, floor_2_p, floor_1_p, floor_0_p};
  assign car_raw  = {floor_4_d, floor_3_d, floor_2_d, floor_1_d, floor_0_d};

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_hall (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (hall_raw[g]),
      .press_evt (hall_evt[g])
    );

    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_car (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (car_raw[g]),
      .press_evt (car_evt[g])
    );
  end

  // Direction selects are async too. Their synchronised value is sampled only
  // in the press-event cycle, so later changes never touch a stored request.
  logic [3:1] dir_meta;
  logic [3:1] dir_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_meta <= '0;
      dir_sync <= '0;
    end else begin
      dir_meta <= {direction_3, direction_2, direction_1};
      dir_sync <= dir_meta;
    end
  end

  req_vec_t              pend_q;
  req_vec_t              pend_nxt;
  req_vec_t              set_v;
  req_vec_t              clr_v;
  logic [NUM_FLOORS-1:0] serve_oh;
  logic                  serve_hit;
  logic                  end_floor;

  always_comb begin
    set_v     = '0;
    clr_v     = '0;
    serve_oh  = '0;
    serve_hit = serve_valid && (current_floor <= FLOOR_W'(FLOOR_TOP));
    end_floor = (current_floor == '0) || (current_floor == FLOOR_W'(FLOOR_TOP));

    // Terminal floors have one possible hall direction each.
    set_v.car          = car_evt;
    set_v.up[0]        = hall_evt[0];
    set_v.dn[FLOOR_TOP] = hall_evt[FLOOR_TOP];
    for (int i = 1; i < FLOOR_TOP; i++) begin
      set_v.up[i] = hall_evt[i] & (dir_sync[i] == DIR_UP);
      set_v.dn[i] = hall_evt[i] & (dir_sync[i] == DIR_DOWN);
    end

    if (serve_hit) serve_oh = floor_onehot(current_floor);
    clr_v.car = serve_oh;
    if (serve_dir == DIR_UP || end_floor)   clr_v.up = serve_oh;
    if (serve_dir == DIR_DOWN || end_floor) clr_v.dn = serve_oh;

    // Clear wins over a coincident set: the doors are already open at that floor.
    pend_nxt = (pend_q | set_v) & ~clr_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      any_pending <= 1'b0;
    end else begin
      pend_q      <= pend_nxt;
      any_pending <= |pend_nxt;
    end
  end

  assign pend_up   = pend_q.up;
  assign pend_down = pend_q.dn;
  assign pend_car  = pend_q.car;

  assign led_inside_0  = pend_q.car[0];
  assign led_inside_1  = pend_q.car[1];
  assign led_inside_2  = pend_q.car[2];
  assign led_inside_3  = pend_q.car[3];
  assign led_inside_4  = pend_q.car[4];

  assign led_outside_0 = pend_q.up[0] | pend_q.dn[0];
  assign led_outside_1 = pend_q.up[1] | pend_q.dn[1];
  assign led_outside_2 = pend_q.up[2] | pend_q.dn[2];
  assign led_outside_3 = pend_q.up[3] | pend_q.dn[3];
  assign led_outside_4 = pend_q.up[4] | pend_q.dn[4];

endmodule

// File: tb/tb_call_request_register.sv
// Directed and randomized bench for call_request_register with DEBOUNCE_CYCLES=4.
// Latency: expects LED 7 cycles after a clean press, 1 cycle after a serve.
// Backpressure: n/a.
module tb_call_request_register;

  logic       clk;
  logic       rst;
  logic [4:0] hall_raw;
  logic [4:0] car_raw;
  logic [3:1] dir_raw;
  logic [2:0] current_floor;
  logic       serve_valid;
  logic       serve_dir;
  logic [4:0] pend_up;
  logic [4:0] pend_down;
  logic [4:0] pend_car;
  logic       li0, li1, li2, li3, li4;
  logic       lo0, lo1, lo2, lo3, lo4;
  logic       any_pending;

  // Reference state: what the spec says should be pending.
  logic [4:0] m_up;
  logic [4:0] m_dn;
  logic [4:0] m_car;

  int n_checks;
  int n_err;

  call_request_register #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .floor_0_p     (hall_raw[0]),
    .floor_1_p     (hall_raw[1]),
    .floor_2_p     (hall_raw[2]),
    .floor_3_p     (hall_raw[3]),
    .floor_4_p     (hall_raw[4]),
    .direction_1   (dir_raw[1]),
    .direction_2   (dir_raw[2]),
    .direction_3   (dir_raw[3]),
    .floor_0_d     (car_raw[0]),
    .floor_1_d     (car_raw[1]),
    .floor_2_d     (car_raw[2]),
    .floor_3_d     (car_raw[3]),
    .floor_4_d     (car_raw[4]),
    .current_floor (current_floor),
    .serve_valid   (serve_valid),
    .serve_dir     (serve_dir),
    .pend_up       (pend_up),
    .pend_down     (pend_down),
    .pend_car      (pend_car),
    .led_inside_0  (li0),
    .led_inside_1  (li1),
    .led_inside_2  (li2),
    .led_inside_3  (li3),
    .led_inside_4  (li4),
    .led_outside_0 (lo0),
    .led_outside_1 (lo1),
    .led_outside_2 (lo2),
    .led_outside_3 (lo3),
    .led_outside_4 (lo4),
    .any_pending   (any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/pend_up"},   pend_up,   m_up);
    chk({tag, "/pend_down"}, pend_down, m_dn);
    chk({tag, "/pend_car"},  pend_car,  m_car);
    chk({tag, "/led_in"},    {li4, li3, li2, li1, li0}, m_car);
    chk({tag, "/led_out"},   {lo4, lo3, lo2, lo1, lo0}, m_up | m_dn);
    chk({tag, "/any"},       {4'b0, any_pending}, {4'b0, |{m_up, m_dn, m_car}});
  endtask

  // Clean press: held well past the debounce window, then released and settled.
  task automatic press_car(input int f);
    car_raw[f] = 1'b1;
    tick(8);
    car_raw[f] = 1'b0;
    tick(8);
    m_car[f] = 1'b1;
  endtask

  task automatic press_hall(input int f, input logic d);
    if (f >= 1 && f <= 3) dir_raw[f] = d;
    tick(3);
    hall_raw[f] = 1'b1;
    tick(8);
    hall_raw[f] = 1'b0;
    tick(8);
    if (f == 0)      m_up[0] = 1'b1;
    else if (f == 4) m_dn[4] = 1'b1;
    else if (d)      m_up[f] = 1'b1;
    else             m_dn[f] = 1'b1;
  endtask

  task automatic serve(input int f, input logic d);
    current_floor = 3'(f);
    serve_dir     = d;
    serve_valid   = 1'b1;
    tick(1);
    serve_valid   = 1'b0;
    if (f <= 4) begin
      m_car[f] = 1'b0;
      if (f == 0 || f == 4) begin
        m_up[f] = 1'b0;
        m_dn[f] = 1'b0;
      end else if (d) begin
        m_up[f] = 1'b0;
      end else begin
        m_dn[f] = 1'b0;
      end
    end
  endtask

  task automatic glitch(input logic is_car, input int f, input int len);
    if (is_car) car_raw[f] = 1'b1;
    else        hall_raw[f] = 1'b1;
    tick(len);
    if (is_car) car_raw[f] = 1'b0;
    else        hall_raw[f] = 1'b0;
    tick(8);
  endtask

  initial begin
    int op;
    int f;
    logic d;

    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    hall_raw      = '0;
    car_raw       = '0;
    dir_raw       = '0;
    current_floor = '0;
    serve_valid   = 1'b0;
    serve_dir     = 1'b0;
    m_up          = '0;
    m_dn          = '0;
    m_car         = '0;

    tick(3);
    chk_all("reset");
    rst = 1'b0;
    tick(5);
    chk_all("idle");

    // Hall floor 3 up: LED exactly 7 cycles after the press.
    dir_raw[3] = 1'b1;
    tick(3);
    hall_raw[3] = 1'b1;
    tick(6);
    chk("lat6/led_out3", {4'b0, lo3}, 5'b0);
    tick(1);
    chk("lat7/led_out3", {4'b0, lo3}, 5'b1);
    chk("lat7/pend_up", pend_up, 5'b01000);
    tick(3);
    hall_raw[3] = 1'b0;
    tick(8);
    m_up[3] = 1'b1;
    chk_all("hall3_up");

    // A 3-cycle glitch is shorter than the debounce window.
    glitch(1'b0, 2, 3);
    glitch(1'b1, 1, 3);
    chk_all("glitch3");

    // Car presses and service at floor 2.
    press_car(2);
    press_car(4);
    chk("car24/pend_car", pend_car, 5'b10100);
    serve(2, 1'b1);
    chk("serve2/pend_car", pend_car, 5'b10000);
    chk_all("serve2");

    // Both hall directions at floor 1, serve downward only.
    press_hall(1, 1'b1);
    press_hall(1, 1'b0);
    chk_all("hall1_both");
    serve(1, 1'b0);
    chk("serve1dn/pend_up1", {4'b0, pend_up[1]}, 5'b1);
    chk("serve1dn/pend_dn1", {4'b0, pend_down[1]}, 5'b0);
    chk("serve1dn/any", {4'b0, any_pending}, 5'b1);
    chk_all("serve1dn");

    // Stored request ignores a later direction change.
    press_hall(2, 1'b1);
    dir_raw[2] = 1'b0;
    tick(6);
    chk_all("dir_change");

    // Press event coinciding with service at floor 0: the request is lost.
    car_raw[0] = 1'b1;
    tick(6);
    current_floor = 3'd0;
    serve_dir     = 1'b1;
    serve_valid   = 1'b1;
    tick(1);
    serve_valid   = 1'b0;
    chk("coincide/pend_car0", {4'b0, pend_car[0]}, 5'b0);
    tick(1);
    chk("coincide_after/pend_car0", {4'b0, pend_car[0]}, 5'b0);
    car_raw[0] = 1'b0;
    tick(8);
    chk_all("coincide");

    // A held button produces one event only.
    car_raw[1] = 1'b1;
    tick(8);
    m_car[1] = 1'b1;
    chk_all("held_set");
    serve(1, 1'b1);
    tick(12);
    chk_all("held_no_reevent");
    car_raw[1] = 1'b0;
    tick(8);

    // Out-of-range service floors leave everything alone.
    serve(6, 1'b1);
    chk_all("serve6");
    serve(7, 1'b0);
    chk_all("serve7");

    // Reset with floor 4 car button held.
    car_raw[4] = 1'b1;
    tick(8);
    m_car[4] = 1'b1;
    chk_all("pre_rst");
    rst = 1'b1;
    tick(1);
    m_up = '0;
    m_dn = '0;
    m_car = '0;
    chk_all("in_rst");
    tick(1);
    rst = 1'b0;
    tick(20);
    chk_all("held_after_rst");
    car_raw[4] = 1'b0;
    tick(10);
    chk_all("released_after_rst");
    press_car(4);
    chk("repress4/pend_car", pend_car, 5'b10000);

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 4));
      f  = int'($urandom_range(0, 4));
      d  = 1'($urandom_range(0, 1));
      case (op)
        0: press_car(f);
        1: begin
          press_hall(f, d);
          dir_raw = 3'($urandom);
        end
        2: serve(int'($urandom_range(0, 7)), d);
        3: glitch(d, f, int'($urandom_range(1, 3)));
        default: serve(f, d);
      endcase
      chk_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
